mem_arbiter: RTL and testbench

// - Sits directly downstream of the processor core. Merges the core's instruction-fetch

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one memory bus, one transaction in flight.
// Optional ARB_ROUND_ROBIN_EN selects round-robin instead of fixed data-over-fetch priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_req_valid,
    output logic                      i_req_ready,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    output logic                      i_rsp_valid,
    output logic [DATA_WIDTH-1:0]     i_rsp_data,
    output logic                      i_rsp_err,
    input  logic                      d_req_valid,
    output logic                      d_req_ready,
    input  logic [ADDR_WIDTH-1:0]     d_req_addr,
    input  logic                      d_req_write,
    input  logic [DATA_WIDTH-1:0]     d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_req_strb,
    output logic                      d_rsp_valid,
    output logic [DATA_WIDTH-1:0]     d_rsp_data,
    output logic                      d_rsp_err,
    output logic                      m_req_valid,
    input  logic                      m_req_ready,
    output logic [ADDR_WIDTH-1:0]     m_req_addr,
    output logic                      m_req_write,
    output logic [DATA_WIDTH-1:0]     m_req_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_req_strb,
    input  logic                      m_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     m_rsp_data,
    input  logic                      m_rsp_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

    state_t state, state_next;
    owner_t owner;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_grant;
`endif

    logic rsp_fire;
    logic can_grant;
    logic grant_data;
    logic grant_instr;
    logic grant_any;

    // A grant may happen in IDLE or in the cycle the outstanding response returns.
    always_comb begin
        rsp_fire  = (state == RESP) && m_rsp_valid;
        can_grant = !reset && ((state == IDLE) || rsp_fire);
`ifdef ARB_ROUND_ROBIN_EN
        grant_data = d_req_valid && (!i_req_valid || (last_grant == OWN_INSTR));
`else
        grant_data = d_req_valid;
`endif
        grant_data  = can_grant && grant_data;
        grant_instr = can_grant && i_req_valid && !grant_data;
        grant_any   = grant_data || grant_instr;
    end

    assign i_req_ready = grant_instr;
    assign d_req_ready = grant_data;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = REQ;
            REQ:     if (m_req_ready) state_next = RESP;
            RESP:    if (rsp_fire) state_next = grant_any ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner       <= OWN_INSTR;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant  <= OWN_INSTR;
`endif
            m_req_valid <= 1'b0;
            m_req_addr  <= '0;
            m_req_write <= 1'b0;
            m_req_wdata <= '0;
            m_req_strb  <= '0;
            i_rsp_valid <= 1'b0;
            i_rsp_data  <= '0;
            i_rsp_err   <= 1'b0;
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= '0;
            d_rsp_err   <= 1'b0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            // m_req_write still describes the finishing transaction even if a new grant lands now.
            if (rsp_fire) begin
                if (owner == OWN_DATA) begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_data  <= m_req_write ? '0 : m_rsp_data;
                    d_rsp_err   <= m_rsp_err;
                end else begin
                    i_rsp_valid <= 1'b1;
                    i_rsp_data  <= m_rsp_data;
                    i_rsp_err   <= m_rsp_err;
                end
            end
            if ((state == REQ) && m_req_ready) m_req_valid <= 1'b0;
            if (grant_any) begin
                m_req_valid <= 1'b1;
                owner       <= grant_data ? OWN_DATA : OWN_INSTR;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant  <= grant_data ? OWN_DATA : OWN_INSTR;
`endif
                if (grant_data) begin
                    m_req_addr  <= d_req_addr;
                    m_req_write <= d_req_write;
                    m_req_wdata <= d_req_wdata;
                    m_req_strb  <= d_req_write ? d_req_strb : '1;
                end else begin
                    m_req_addr  <= i_req_addr;
                    m_req_write <= 1'b0;
                    m_req_wdata <= '0;
                    m_req_strb  <= '1;
                end
            end
        end
    end

    // A bus response with nothing outstanding is dropped; flag it in simulation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!m_rsp_valid || (state == RESP))
                else $warning("mem_arbiter: m_rsp_valid outside RESP ignored");
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle plus literal expectations.
// Build with ARB_ROUND_ROBIN_EN defined to check the round-robin variant.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_rsp_data;
    logic          d_req_valid, d_req_ready, d_req_write, d_rsp_valid, d_rsp_err;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata, d_rsp_data;
    logic [SW-1:0] d_req_strb;
    logic          m_req_valid, m_req_ready, m_req_write, m_rsp_valid, m_rsp_err;
    logic [AW-1:0] m_req_addr;
    logic [DW-1:0] m_req_wdata, m_rsp_data;
    logic [SW-1:0] m_req_strb;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_write(d_req_write), .d_req_wdata(d_req_wdata), .d_req_strb(d_req_strb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
        .m_req_write(m_req_write), .m_req_wdata(m_req_wdata), .m_req_strb(m_req_strb),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .m_rsp_err(m_rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Bus responder configuration
    int            bus_stall = 0;
    bit            hold_rsp = 0;
    bit            stray_rsp = 0;
    logic [AW-1:0] err_addr = 32'hFFFF_FFFF;
    bit            rsp_pending = 0;
    int            stall_cnt = 0;
    logic [AW-1:0] rsp_addr = '0;

    // Transaction-level model of what the arbiter must show
    bit            busy = 0, bus_taken = 0, txn_data = 0, txn_write = 0, last_was_data = 0;
    bit            exp_mv = 0, exp_write = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [SW-1:0] exp_strb = '0;
    bit            exp_i_valid = 0, exp_i_err = 0, exp_d_valid = 0, exp_d_err = 0;
    logic [DW-1:0] exp_i_data = '0, exp_d_data = '0;
    bit            free, want_d, want_i;

    // Observations used by the literal checks
    int            i_acc_cyc = 0, d_acc_cyc = 0, i_rsp_cyc = 0, d_rsp_cyc = 0;
    int            i_rsp_cnt = 0, d_rsp_cnt = 0, mv_cnt = 0;
    logic [DW-1:0] seen_i_data = '0, seen_d_data = '0;
    logic          seen_i_err = 1'b0, seen_d_err = 1'b0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        case (a)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0300: return 32'hCAFE_F00D;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    function automatic bit pick_data(input bit iv, input bit dv, input bit last_data);
        if (!dv) return 1'b0;
        if (!iv) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return !last_data;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic apply_stimulus(input bit is_data, input logic [AW-1:0] addr, input logic write,
                                  input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (is_data) begin
            d_req_valid = 1'b1; d_req_addr = addr; d_req_write = write;
            d_req_wdata = wdata; d_req_strb = strb;
        end else begin
            i_req_valid = 1'b1; i_req_addr = addr;
        end
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = is_data ? d_req_ready : i_req_ready;
        end
        check_output(is_data ? "data_accept_seen" : "fetch_accept_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
        if (is_data) d_req_valid = 1'b0;
        else         i_req_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        i_rsp_cnt = 0; d_rsp_cnt = 0; mv_cnt = 0;
    endtask

    // Bus slave: accepts after bus_stall cycles, responds the following cycle.
    initial begin
        m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = '0; m_rsp_err = 1'b0;
        forever begin
            @(posedge clk); #2;
            m_req_ready = 1'b0;
            m_rsp_valid = 1'b0;
            if (reset) begin
                rsp_pending = 0;
                stall_cnt = 0;
            end else begin
                if (rsp_pending && !hold_rsp) begin
                    m_rsp_valid = 1'b1;
                    m_rsp_data  = mem_word(rsp_addr);
                    m_rsp_err   = (rsp_addr == err_addr);
                    rsp_pending = 0;
                end else if (stray_rsp) begin
                    m_rsp_valid = 1'b1;
                    m_rsp_data  = 32'hBAD0_BAD0;
                    m_rsp_err   = 1'b1;
                    stray_rsp   = 0;
                end
                if (m_req_valid && !rsp_pending) begin
                    if (stall_cnt >= bus_stall) begin
                        m_req_ready = 1'b1;
                        rsp_pending = 1;
                        rsp_addr    = m_req_addr;
                        stall_cnt   = 0;
                    end else begin
                        stall_cnt++;
                    end
                end
            end
        end
    end

    // Every cycle: compare against the model, then advance the model across the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check_output("m_req_valid", 64'(m_req_valid), 64'(exp_mv));
            check_output("m_req_addr", 64'(m_req_addr), 64'(exp_addr));
            check_output("m_req_write", 64'(m_req_write), 64'(exp_write));
            check_output("m_req_strb", 64'(m_req_strb), 64'(exp_strb));
            if (exp_write) check_output("m_req_wdata", 64'(m_req_wdata), 64'(exp_wdata));
            check_output("i_rsp_valid", 64'(i_rsp_valid), 64'(exp_i_valid));
            check_output("i_rsp_data", 64'(i_rsp_data), 64'(exp_i_data));
            check_output("i_rsp_err", 64'(i_rsp_err), 64'(exp_i_err));
            check_output("d_rsp_valid", 64'(d_rsp_valid), 64'(exp_d_valid));
            check_output("d_rsp_data", 64'(d_rsp_data), 64'(exp_d_data));
            check_output("d_rsp_err", 64'(d_rsp_err), 64'(exp_d_err));

            free   = !busy || (bus_taken && m_rsp_valid);
            want_d = !reset && free && pick_data(i_req_valid, d_req_valid, last_was_data);
            want_i = !reset && free && i_req_valid && !want_d;
            check_output("i_req_ready", 64'(i_req_ready), 64'(want_i));
            check_output("d_req_ready", 64'(d_req_ready), 64'(want_d));

            if (i_req_ready) i_acc_cyc = cyc;
            if (d_req_ready) d_acc_cyc = cyc;
            if (m_req_valid) mv_cnt++;
            if (i_rsp_valid) begin
                i_rsp_cnt++; i_rsp_cyc = cyc; seen_i_data = i_rsp_data; seen_i_err = i_rsp_err;
            end
            if (d_rsp_valid) begin
                d_rsp_cnt++; d_rsp_cyc = cyc; seen_d_data = d_rsp_data; seen_d_err = d_rsp_err;
            end

            if (reset) begin
                busy = 0; bus_taken = 0; last_was_data = 0;
                exp_mv = 0; exp_write = 0; exp_addr = '0; exp_wdata = '0; exp_strb = '0;
                exp_i_valid = 0; exp_i_data = '0; exp_i_err = 0;
                exp_d_valid = 0; exp_d_data = '0; exp_d_err = 0;
            end else begin
                exp_i_valid = 0;
                exp_d_valid = 0;
                if (busy && bus_taken && m_rsp_valid) begin
                    if (txn_data) begin
                        exp_d_valid = 1;
                        exp_d_data  = txn_write ? '0 : m_rsp_data;
                        exp_d_err   = m_rsp_err;
                    end else begin
                        exp_i_valid = 1;
                        exp_i_data  = m_rsp_data;
                        exp_i_err   = m_rsp_err;
                    end
                    busy = 0;
                end
                if (busy && !bus_taken && m_req_ready) begin
                    bus_taken = 1;
                    exp_mv = 0;
                end
                if (want_d || want_i) begin
                    busy = 1; bus_taken = 0; exp_mv = 1;
                    txn_data  = want_d;
                    txn_write = want_d && d_req_write;
                    exp_addr  = want_d ? d_req_addr : i_req_addr;
                    exp_write = txn_write;
                    exp_wdata = d_req_wdata;
                    exp_strb  = txn_write ? d_req_strb : '1;
                    last_was_data = want_d;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_write = 1'b0; d_req_wdata = '0; d_req_strb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_m_req_valid", 64'(m_req_valid), 64'd0);
        check_output("reset_i_rsp_data", 64'(i_rsp_data), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] single fetch, zero-wait bus");
        bus_stall = 0; clear_counts();
        apply_stimulus(1'b0, 32'h100, 1'b0, '0, '0);
        wait_cycles(6);
        check_output("fetch_latency", 64'(i_rsp_cyc - i_acc_cyc), 64'd3);
        check_output("fetch_data", 64'(seen_i_data), 64'hDEAD_BEEF);
        check_output("fetch_rsp_count", 64'(i_rsp_cnt), 64'd1);
        check_output("fetch_no_data_rsp", 64'(d_rsp_cnt), 64'd0);

        $display("[TB] store with four stall cycles");
        bus_stall = 4; clear_counts();
        apply_stimulus(1'b1, 32'h200, 1'b1, 32'h1122_3344, 4'b0011);
        wait_cycles(10);
        check_output("store_req_cycles", 64'(mv_cnt), 64'd5);
        check_output("store_rsp_count", 64'(d_rsp_cnt), 64'd1);
        check_output("store_rsp_data", 64'(seen_d_data), 64'd0);
        check_output("store_no_fetch_rsp", 64'(i_rsp_cnt), 64'd0);

        $display("[TB] fetch and load together");
        bus_stall = 0; clear_counts();
        fork
            apply_stimulus(1'b1, 32'h300, 1'b0, '0, 4'b0000);
            apply_stimulus(1'b0, 32'h104, 1'b0, '0, '0);
        join
        wait_cycles(6);
`ifdef ARB_ROUND_ROBIN_EN
        check_output("rr_load_after_fetch", 64'(d_acc_cyc - i_acc_cyc), 64'd2);
`else
        check_output("fixed_fetch_after_load", 64'(i_acc_cyc - d_acc_cyc), 64'd2);
`endif
        check_output("both_load_data", 64'(seen_d_data), 64'hCAFE_F00D);
        check_output("both_fetch_data", 64'(seen_i_data), 64'hA5A5_0104);

        $display("[TB] load with bus error, then clean fetch");
        err_addr = 32'h500; clear_counts();
        apply_stimulus(1'b1, 32'h500, 1'b0, '0, '0);
        wait_cycles(5);
        check_output("err_load_rsp_count", 64'(d_rsp_cnt), 64'd1);
        check_output("err_load_err", 64'(seen_d_err), 64'd1);
        check_output("err_load_data", 64'(seen_d_data), 64'hA5A5_0500);
        apply_stimulus(1'b0, 32'h504, 1'b0, '0, '0);
        wait_cycles(5);
        check_output("after_err_fetch_err", 64'(seen_i_err), 64'd0);
        check_output("after_err_fetch_count", 64'(i_rsp_cnt), 64'd1);
        err_addr = 32'hFFFF_FFFF;

        $display("[TB] reset while fetch response outstanding");
        hold_rsp = 1; clear_counts();
        apply_stimulus(1'b0, 32'h600, 1'b0, '0, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        hold_rsp = 0;
        @(negedge clk);
        check_output("post_reset_m_req_addr", 64'(m_req_addr), 64'd0);
        check_output("post_reset_i_rsp_data", 64'(i_rsp_data), 64'd0);
        wait_cycles(4);
        check_output("reset_dropped_rsp", 64'(i_rsp_cnt + d_rsp_cnt), 64'd0);
        apply_stimulus(1'b0, 32'h100, 1'b0, '0, '0);
        wait_cycles(5);
        check_output("post_reset_fetch_data", 64'(seen_i_data), 64'hDEAD_BEEF);
        check_output("post_reset_fetch_latency", 64'(i_rsp_cyc - i_acc_cyc), 64'd3);

        $display("[TB] stray bus response in IDLE");
        clear_counts();
        @(posedge clk); #1;
        stray_rsp = 1;
        wait_cycles(4);
        check_output("stray_ignored", 64'(i_rsp_cnt + d_rsp_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
